// File: rtl/icebus_motor_responder.sv
// ============================================================================
// Module   : icebus_motor_responder
// Purpose  : iCEbus UART command receiver and status-frame responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icebus_motor_responder #(
  parameter int         CLOCK_FREQ_HZ   = 50_000_000,
  parameter int         BAUDRATE        = 2_000_000,
  parameter logic [7:0] MY_ID           = 8'd128,
  parameter int         TURNAROUND_BITS = 2,
  parameter int         TIMEOUT_BITS    = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_i,
  output logic               tx_o,
  output logic               tx_en,
  input  logic signed [23:0] encoder0_position,
  input  logic signed [15:0] current,
  output logic signed [23:0] setpoint,
  output logic [7:0]         control_mode,
  output logic               setpoint_valid,
  output logic [15:0]        frame_count,
  output logic [15:0]        crc_error_count
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUDRATE;
  localparam int MAX_COUNT    = (TIMEOUT_BITS + TURNAROUND_BITS + 1) * CLKS_PER_BIT;
  localparam int CW           = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TURNAROUND_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TIMEOUT   = CW'(TIMEOUT_BITS * CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT, P_ID, P_CMD, P_P2, P_P1, P_P0, P_CRC} p_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [9:0] word;
    word = {1'b1, data, 1'b0};
    return word[idx];
  endfunction

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            byte_valid, frame_err;

  p_state_t        p_state;
  logic [7:0]      frame_id, cmd, crc_acc;
  logic [23:0]     payload;
  logic [CW-1:0]   gap_cnt;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [2:0]      tx_byte;
  logic [63:0]     tx_frame;
  logic [7:0]      resp_crc;

  logic            tx_busy, accept_now;

  assign tx_busy    = (tx_state != TX_IDLE);
  assign accept_now = byte_valid && !tx_busy && (p_state == P_CRC) &&
                      (frame_id == MY_ID) && (rx_shift == crc_acc);

  always_comb begin
    resp_crc = crc8_byte(8'h00, MY_ID);
    resp_crc = crc8_byte(resp_crc, encoder0_position[23:16]);
    resp_crc = crc8_byte(resp_crc, encoder0_position[15:8]);
    resp_crc = crc8_byte(resp_crc, encoder0_position[7:0]);
    resp_crc = crc8_byte(resp_crc, current[15:8]);
    resp_crc = crc8_byte(resp_crc, current[7:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte receiver; parked while our own response owns the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tx_busy) begin
        rx_state <= RX_IDLE;
      end else begin
        case (rx_state)
          RX_IDLE: if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
          RX_START: if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
          RX_DATA: if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
          RX_STOP: if (rx_cnt == BIT_LAST) begin
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state         <= P_HUNT;
      frame_id        <= '0;
      cmd             <= '0;
      payload         <= '0;
      crc_acc         <= '0;
      gap_cnt         <= '0;
      setpoint        <= '0;
      control_mode    <= '0;
      setpoint_valid  <= 1'b0;
      frame_count     <= '0;
      crc_error_count <= '0;
    end else begin
      setpoint_valid <= 1'b0;
      if (tx_busy) begin
        p_state <= P_HUNT;
      end else if (frame_err) begin
        p_state <= P_HUNT;
        if (crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 16'd1;
      end else if (byte_valid) begin
        gap_cnt <= '0;
        case (p_state)
          P_HUNT: if (rx_shift == 8'h55) begin
            p_state <= P_ID;
            crc_acc <= 8'h00;
          end
          P_ID: begin
            frame_id <= rx_shift;
            crc_acc  <= crc8_byte(crc_acc, rx_shift);
            p_state  <= P_CMD;
          end
          P_CMD: begin
            cmd     <= rx_shift;
            crc_acc <= crc8_byte(crc_acc, rx_shift);
            p_state <= P_P2;
          end
          P_P2: begin
            payload[23:16] <= rx_shift;
            crc_acc        <= crc8_byte(crc_acc, rx_shift);
            p_state        <= P_P1;
          end
          P_P1: begin
            payload[15:8] <= rx_shift;
            crc_acc       <= crc8_byte(crc_acc, rx_shift);
            p_state       <= P_P0;
          end
          P_P0: begin
            payload[7:0] <= rx_shift;
            crc_acc      <= crc8_byte(crc_acc, rx_shift);
            p_state      <= P_CRC;
          end
          P_CRC: begin
            p_state <= P_HUNT;
            // Foreign IDs are dropped before the CRC is even looked at.
            if (frame_id == MY_ID) begin
              if (rx_shift != crc_acc) begin
                if (crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 16'd1;
              end else begin
                frame_count <= frame_count + 16'd1;
                if (cmd == 8'h01) begin
                  setpoint       <= payload;
                  setpoint_valid <= 1'b1;
                end else if (cmd == 8'h02) begin
                  control_mode   <= payload[7:0];
                  setpoint_valid <= 1'b1;
                end
              end
            end
          end
          default: p_state <= P_HUNT;
        endcase
      end else if (p_state != P_HUNT) begin
        if (rx_state != RX_IDLE) gap_cnt <= '0;
        else if (gap_cnt == TIMEOUT) begin
          p_state <= P_HUNT;
          gap_cnt <= '0;
        end else gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // The frame is latched from live inputs on acceptance, which is the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_frame <= '0;
      tx_o     <= 1'b1;
      tx_en    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_o  <= 1'b1;
          tx_en <= 1'b0;
          if (accept_now) begin
            tx_state <= TX_WAIT;
            tx_cnt   <= '0;
            tx_frame <= {8'h55, MY_ID, encoder0_position, current, resp_crc};
          end
        end
        TX_WAIT: if (tx_cnt == WAIT_LAST) begin
          tx_state <= TX_SEND;
          tx_en    <= 1'b1;
          tx_o     <= 1'b0;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_byte  <= '0;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_SEND: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            if (tx_byte == 3'd7) begin
              tx_state <= TX_IDLE;
              tx_en    <= 1'b0;
              tx_o     <= 1'b1;
            end else begin
              tx_byte  <= tx_byte + 3'd1;
              tx_bit   <= '0;
              tx_o     <= 1'b0;
              tx_frame <= {tx_frame[55:0], 8'h00};
            end
          end else begin
            tx_bit <= tx_bit + 4'd1;
            tx_o   <= frame_bit(tx_frame[63:56], tx_bit + 4'd1);
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/icebus_motor_responder.md
Name: icebus_motor_responder

Overview:
- Motor-board end of the iCEbus UART link: receives command frames from the FPGA bus master, updates setpoint and control mode, and answers every accepted frame with a status frame.
- Half-duplex, 8N1. Frames carry a CRC-8 and a motor ID; frames addressed to other IDs are ignored.
- Sits between the board's UART pins and the local PID/encoder/current-sense logic.

Parameters:
- CLOCK_FREQ_HZ, 50_000_000, system clock frequency.
- BAUDRATE, 2_000_000, line rate. CLKS_PER_BIT = CLOCK_FREQ_HZ/BAUDRATE (integer, must be ≥ 4).
- MY_ID, 128, 8-bit motor ID this responder answers to.
- TURNAROUND_BITS, 2, idle bit times between the command's final stop-bit sample and the response's start bit.
- TIMEOUT_BITS, 20, maximum idle gap between bytes inside one frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_i  in  1  UART receive line, idle high, asynchronous to clk
- tx_o  out  1  UART transmit line, idle high
- tx_en  out  1  line-driver enable, high while transmitting
- encoder0_position  in  24  signed position, snapshotted for the status frame
- current  in  16  signed current, snapshotted for the status frame
- setpoint  out  24  signed setpoint, last accepted value
- control_mode  out  8  last accepted control mode
- setpoint_valid  out  1  one-cycle pulse when setpoint or control_mode updates
- frame_count  out  16  accepted frames, wraps at 0xFFFF to 0
- crc_error_count  out  16  CRC and framing errors, saturates at 0xFFFF

Behaviour:
- Reset values: tx_o=1, tx_en=0, setpoint=0, control_mode=0, setpoint_valid=0, both counters=0. All state machines return to HUNT/IDLE on the next edge, including mid-frame or mid-transmit.
- Sync/RX: rx_i passes through a 2-flop synchronizer.
  - A falling edge starts a byte; the line is sampled at CLKS_PER_BIT/2 into each bit.
  - If the start bit is high at mid-sample, it is a false start: discard, no error.
  - Data is LSB first. If the stop bit is sampled low, it is a framing error: increment crc_error_count, parser to HUNT.
- Command frame (7 bytes): 0x55, ID, CMD, P2, P1, P0, CRC.
  - P2 is the MSB of the 24-bit payload.
  - CRC is CRC-8, poly 0x07, init 0x00, MSB-first, computed over ID..P0.
- Parser states:
  - HUNT: waits for byte 0x55. Any other byte is dropped silently.
  - ID, CMD, PAYLOAD(3), CRC: collect the remaining bytes.
  - If the gap between bytes after the 0x55 exceeds TIMEOUT_BITS×CLKS_PER_BIT, return to HUNT with no count change.
- Frame checks, on CRC byte receipt:
  - ID≠MY_ID: drop silently, with no CRC check and no count change.
  - CRC mismatch: increment crc_error_count, no response.
  - Otherwise the frame is accepted; actions below.
- Accepted frame actions:
  - frame_count increments.
  - encoder0_position and current are snapshotted in the same cycle.
  - CMD 0x01: setpoint <= payload, setpoint_valid pulses.
  - CMD 0x02: control_mode <= P0, setpoint_valid pulses.
  - CMD 0x03: status request only.
  - Any other CMD: accepted and answered, no register change.
  - setpoint_valid pulses exactly 1 cycle after CRC-byte stop sample.
- Response frame (8 bytes): 0x55, MY_ID, E2, E1, E0, C1, C0, CRC.
  - E = snapshotted encoder0_position, C = snapshotted current, both MSB first.
  - CRC uses the same polynomial, computed over MY_ID..C0.
- TX states:
  - IDLE → WAIT: on acceptance, count TURNAROUND_BITS×CLKS_PER_BIT cycles.
  - WAIT → SEND: tx_en rises at WAIT exit; start bit is driven the same cycle.
  - SEND: transmits 8 bytes back to back, each CLKS_PER_BIT per bit with 1 stop bit.
  - SEND → IDLE: tx_en falls and tx_o=1 after the last stop bit completes.
- Half duplex: the receiver is held in HUNT and ignores rx_i while in WAIT or SEND. Bytes arriving then are lost and not counted.
- Counters: crc_error_count holds at 0xFFFF. frame_count wraps.

Test Plan:
- Valid CMD 0x01 frame to ID 128, payload 0xFFF830 (-2000) → setpoint=-2000, one setpoint_valid pulse, frame_count=1; response starts 2 bit times after the stop bit (50 clk at defaults) and contains 0x55,0x80 plus the encoder/current snapshot bytes with a correct CRC, 8 bytes total.
- Same frame with the CRC byte flipped → no response, tx_en stays 0, crc_error_count=1, setpoint unchanged.
- Frame to ID 0x81 → no response, no count change. Then a frame to 0x80 with CMD 0x02, P0=0x03 → control_mode=3, response sent.
- Stop bit forced low on byte 3 → crc_error_count=1. The next valid frame is accepted normally.
- Inter-byte gap of 25 bit times after the ID byte, then the remaining bytes → no response. Then a full valid frame → accepted.
- Reset asserted mid-response at byte 4 → next edge tx_o=1, tx_en=0, all outputs at reset values. A fresh frame afterwards gets a full response.
